ram_dev: RTL
============

Name: ram_dev

Overview:
- Behavioural RAM device model that sits directly downstream of the motherboard controller on the shared addr/data bus.
- Consumes the RAM read/write request pins of the controller's RAM control word and returns the acknowledge pin.
- Completes a four-phase request/ack handshake with configurable access latency.
- Stores 32-bit words in an internal array and returns read data on a dedicated bus.

Parameters:
ADDR_BITS, 10, number of word-address bits used; array depth = 2**ADDR_BITS words.
LATENCY, 3, clock edges from request acceptance to ack assertion; legal range 1..255.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
ram_ctrl_in  input  32  control word from controller; bit `RAM_WRITE_PIN = write request, bit `RAM_READ_PIN = read request, other bits ignored
ram_ctrl_out  output  32  control word to controller; bit `RAM_ACK = ack, all other bits always 0
addr  input  32  word address; only addr[ADDR_BITS-1:0] used, upper bits ignored (aliasing wrap)
data_in  input  32  write data
data_out  output  32  read data, registered
ram_err  output  1  sticky error flag: set when both request pins are seen high in IDLE

Behaviour:
- Reset (async, rst high):
  - state=IDLE, ack=0, data_out=0, ram_err=0, latency counter=0.
  - Memory array contents are NOT cleared; they survive reset, including a reset in mid-access.
  - An access interrupted by reset is abandoned: a write not yet committed is lost, no ack is issued.
- States: IDLE, BUSY, ACK.
- IDLE (ack=0):
  - Exactly one of write/read request pins high at a rising edge (edge E0): latch op, addr[ADDR_BITS-1:0] and data_in; load cnt=LATENCY-1; go to BUSY.
  - Both request pins high: no access, set ram_err=1, stay in IDLE.
  - Neither pin high: stay in IDLE.
- BUSY:
  - cnt!=0: decrement cnt; bus changes are ignored because latched values are used.
  - cnt==0: perform the op. Write stores the latched data at the latched address. Read loads data_out from the latched address. Then set ack=1 and go to ACK.
  - Net latency: ack is visible after edge E0+LATENCY.
- ACK (ack=1):
  - Hold ack and data_out while either request pin is high.
  - On the first edge with both pins low: ack=0, go to IDLE.
  - The earliest next request acceptance is the edge after ack falls; a request present on the same edge ack drops is not accepted.
- data_out changes only on read completion or reset; writes leave it unchanged.
- Read-after-write to the same address in consecutive handshakes returns the new data.
- Request pins dropping while in BUSY (protocol violation): the access still completes, ack rises, then falls on the next edge because the pins are already low.
- Requests that use other control-word bits (e.g. VGA pins) on the shared bus do not trigger any action.

Test Plan:
- Write handshake: LATENCY=3, assert write pin with addr=5, data_in=0x1234 at E0 -> ack=1 after E3; drop pin -> ack=0 after the next edge; data_out stays 0.
- Read-back: after the write above, assert read pin with addr=5 -> after E0+3 ack=1 and data_out=0x1234, both held until the pin drops.
- Address aliasing: ADDR_BITS=10, write 0xAA at addr=0x405, then read addr=0x005 -> data_out=0xAA.
- Simultaneous pins: write and read pins both high in IDLE -> ram_err=1 (sticky), ack stays 0, memory unchanged (read addr afterwards returns the prior value).
- Reset mid-access: write addr=7 data=0x55 accepted, rst pulsed one cycle later -> ack=0, data_out=0, state IDLE; subsequent read of addr 7 returns the old contents, not 0x55. A prior write at addr 5 is still 0x1234.
- Back-to-back loop: controller-style sequence of write idx, read idx for idx=0..15 with LATENCY=1 -> each read returns idx, ack never high while both pins are low for more than one edge, no ram_err.

Source files
------------

// File: rtl/ram_dev.sv
// ram_dev: behavioural RAM device on the shared addr/data bus.
//
// The device accepts one access at a time through a four-phase request/ack
// handshake. It samples the write/read request pins of the controller's RAM
// control word and answers with the ack pin LATENCY clock edges after it
// accepts the request.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   rst          asynchronous active-high reset (the memory array is kept)
//   ram_ctrl_in  control word; RAM_WRITE_PIN / RAM_READ_PIN request bits
//   ram_ctrl_out control word back to the controller; only RAM_ACK is driven
//   addr         word address; only addr[ADDR_BITS-1:0] is used (aliasing)
//   data_in      write data
//   data_out     registered read data; changes only on read completion/reset
//   ram_err      sticky flag, set when both request pins are high in IDLE

`ifndef RAM_WRITE_PIN
`define RAM_WRITE_PIN 0
`endif
`ifndef RAM_READ_PIN
`define RAM_READ_PIN 1
`endif
`ifndef RAM_ACK
`define RAM_ACK 0
`endif

module ram_dev #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ram_ctrl_in,
  output logic [31:0] ram_ctrl_out,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ram_err
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [7:0]             cnt_reg, cnt_next;
  logic                   ack_reg, ack_next;
  logic                   err_reg, err_next;
  logic                   op_wr_reg;
  logic [ADDR_BITS-1:0]   lat_addr_reg;
  logic [31:0]            lat_data_reg;
  logic [31:0]            data_out_reg;

  logic                   latch_en;
  logic                   do_write;
  logic                   do_read;

  logic [31:0]            mem [DEPTH];

  wire wr_pin = ram_ctrl_in[`RAM_WRITE_PIN];
  wire rd_pin = ram_ctrl_in[`RAM_READ_PIN];

  // Upper address bits and the non-RAM control bits are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{addr[31:ADDR_BITS], ram_ctrl_in};

  // Next-state / control decode.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ack_next   = ack_reg;
    err_next   = err_reg;
    latch_en   = 1'b0;
    do_write   = 1'b0;
    do_read    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wr_pin ^ rd_pin) begin
          latch_en   = 1'b1;
          cnt_next   = 8'(LATENCY - 1);
          state_next = BUSY;
        end else if (wr_pin && rd_pin) begin
          err_next = 1'b1;
        end
      end
      BUSY: begin
        // The access completes even if the pins have already dropped; the
        // ACK state then releases on the following edge.
        if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
        end else begin
          do_write   = op_wr_reg;
          do_read    = !op_wr_reg;
          ack_next   = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        if (!wr_pin && !rd_pin) begin
          ack_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        ack_next   = 1'b0;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // Control state and request latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 8'd0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      op_wr_reg    <= 1'b0;
      lat_addr_reg <= '0;
      lat_data_reg <= '0;
      data_out_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      if (latch_en) begin
        op_wr_reg    <= wr_pin;
        lat_addr_reg <= addr[ADDR_BITS-1:0];
        lat_data_reg <= data_in;
      end
      if (do_read) begin
        data_out_reg <= mem[lat_addr_reg];
      end
    end
  end

  // Memory array has no reset so its contents survive rst. A reset during
  // BUSY forces state to IDLE asynchronously, so do_write never fires for
  // the abandoned access.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[lat_addr_reg] <= lat_data_reg;
    end
  end

  always_comb begin
    ram_ctrl_out           = '0;
    ram_ctrl_out[`RAM_ACK] = ack_reg;
  end

  assign data_out = data_out_reg;
  assign ram_err  = err_reg;

endmodule
